// File: rtl/commu_uart_bridge.sv
// UART-slave to fx-bus-master bridge: RX/TX PHY with internal baud timing and a framed
// write/read command decoder. Define COMMU_UART_PARITY_EN for 11-bit characters with even parity.
module commu_uart_bridge #(
    parameter int BAUD_DIV     = 868,
    parameter int AW           = 22,
    parameter int RD_LAT       = 1,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          uart_rx,
    output logic          uart_tx,
    output logic          fx_wr,
    output logic [AW-1:0] fx_waddr,
    output logic [7:0]    fx_data,
    output logic          fx_rd,
    output logic [AW-1:0] fx_raddr,
    input  logic [7:0]    fx_q,
    output logic          busy,
    output logic [2:0]    dbg_state_o
);

    localparam int AB     = (AW + 7) / 8;
    localparam int BW     = $clog2(BAUD_DIV);
    localparam int HALF   = BAUD_DIV / 2;
`ifdef COMMU_UART_PARITY_EN
    localparam int NDB    = 9;
`else
    localparam int NDB    = 8;
`endif
    localparam int NTB    = NDB + 2;
    localparam int TO_CYC = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW     = $clog2(TO_CYC + 1);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    // Internal handshakes: rx_valid_q/rx_err_q are single-cycle pulses with no backpressure
    // (a consumer that is not listening simply loses the byte); tx_start_q is a one-cycle
    // request taken only while the transmitter is idle, and tx_done_q pulses at stop-bit end.

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

    rx_state_e        rx_state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BW-1:0]    rx_cnt_q;
    logic [3:0]       rx_bit_q;
    logic [NDB-1:0]   rx_sh_q;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q, rx_err_q;
    logic             par_ok_d;

`ifdef COMMU_UART_PARITY_EN
    assign par_ok_d = ~(^rx_sh_q);
`else
    assign par_ok_d = 1'b1;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (rx_cnt_q == BW'(HALF - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_BITS;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + BW'(1);
                    end
                end
                RX_BITS: begin
                    if (rx_cnt_q == BW'(BAUD_DIV - 1)) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[NDB-1:1]};
                        rx_bit_q <= rx_bit_q + 4'd1;
                        if (rx_bit_q == 4'(NDB - 1)) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + BW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BW'(BAUD_DIV - 1)) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                        rx_byte_q  <= rx_sh_q[7:0];
                        if (rx_sync_q && par_ok_d) begin
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + BW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    logic             tx_busy_q, tx_done_q, tx_line_q;
    logic [BW-1:0]    tx_cnt_q;
    logic [3:0]       tx_bit_q;
    logic [NDB:0]     tx_sh_q;
    logic [NDB:0]     tx_frame_d;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;

`ifdef COMMU_UART_PARITY_EN
    assign tx_frame_d = {1'b1, ^tx_data_q, tx_data_q};
`else
    assign tx_frame_d = {1'b1, tx_data_q};
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            tx_line_q <= 1'b1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (tx_start_q) begin
                    tx_busy_q <= 1'b1;
                    tx_line_q <= 1'b0;
                    tx_sh_q   <= tx_frame_d;
                    tx_cnt_q  <= '0;
                    tx_bit_q  <= '0;
                end
            end else if (tx_cnt_q == BW'(BAUD_DIV - 1)) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'(NTB - 1)) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                    tx_line_q <= 1'b1;
                end else begin
                    tx_line_q <= tx_sh_q[0];
                    tx_sh_q   <= {1'b1, tx_sh_q[NDB:1]};
                    tx_bit_q  <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + BW'(1);
            end
        end
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_RD_ISSUE, S_RD_WAIT, S_RD_TX, S_RESP
    } state_e;

    state_e           state_q;
    logic             is_wr_q;
    logic [AW-1:0]    addr_q;
    logic [3:0]       abyte_q;
    logic [8:0]       len_q;
    logic [TW-1:0]    tout_q;
    logic [2:0]       lat_q;
    logic             fx_wr_q, fx_rd_q;
    logic [AW-1:0]    fx_waddr_q, fx_raddr_q;
    logic [7:0]       fx_data_q;

    logic             in_frame_d, abort_d;
    logic [AW+7:0]    addr_ext_d;
    logic [AW-1:0]    addr_shift_d;

    assign in_frame_d   = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_WDATA);
    assign abort_d      = in_frame_d && !rx_valid_q &&
                          (rx_err_q || (tout_q == TW'(TO_CYC - 1)));
    // Bits shifted past the top of the address register are the ones above AW.
    assign addr_ext_d   = {addr_q, rx_byte_q};
    assign addr_shift_d = addr_ext_d[AW-1:0];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            abyte_q    <= '0;
            len_q      <= '0;
            tout_q     <= '0;
            lat_q      <= '0;
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_raddr_q <= '0;
            fx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tout_q     <= (in_frame_d && !rx_valid_q) ? tout_q + TW'(1) : '0;
            if (abort_d) begin
                tx_data_q  <= NAK;
                tx_start_q <= 1'b1;
                state_q    <= S_RESP;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx_valid_q) begin
                            if (rx_byte_q == CMD_WR || rx_byte_q == CMD_RD) begin
                                is_wr_q <= (rx_byte_q == CMD_WR);
                                addr_q  <= '0;
                                abyte_q <= '0;
                                state_q <= S_ADDR;
                            end else begin
                                tx_data_q  <= NAK;
                                tx_start_q <= 1'b1;
                                state_q    <= S_RESP;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rx_valid_q) begin
                            addr_q  <= addr_shift_d;
                            abyte_q <= abyte_q + 4'd1;
                            if (abyte_q == 4'(AB - 1)) begin
                                state_q <= S_LEN;
                            end
                        end
                    end
                    S_LEN: begin
                        if (rx_valid_q) begin
                            len_q   <= (rx_byte_q == 8'h00) ? 9'd256 : {1'b0, rx_byte_q};
                            state_q <= is_wr_q ? S_WDATA : S_RD_ISSUE;
                        end
                    end
                    S_WDATA: begin
                        if (rx_valid_q) begin
                            fx_wr_q    <= 1'b1;
                            fx_waddr_q <= addr_q;
                            fx_data_q  <= rx_byte_q;
                            addr_q     <= addr_q + AW'(1);
                            len_q      <= len_q - 9'd1;
                            if (len_q == 9'd1) begin
                                tx_data_q  <= ACK;
                                tx_start_q <= 1'b1;
                                state_q    <= S_RESP;
                            end
                        end
                    end
                    S_RD_ISSUE: begin
                        fx_rd_q    <= 1'b1;
                        fx_raddr_q <= addr_q;
                        lat_q      <= '0;
                        state_q    <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        // lat_q is 0 in the cycle fx_rd is high, so fx_q is taken RD_LAT cycles later.
                        if (lat_q == 3'(RD_LAT)) begin
                            tx_data_q  <= fx_q;
                            tx_start_q <= 1'b1;
                            state_q    <= S_RD_TX;
                        end else begin
                            lat_q <= lat_q + 3'd1;
                        end
                    end
                    S_RD_TX: begin
                        if (tx_done_q) begin
                            addr_q  <= addr_q + AW'(1);
                            len_q   <= len_q - 9'd1;
                            state_q <= (len_q == 9'd1) ? S_IDLE : S_RD_ISSUE;
                        end
                    end
                    S_RESP: begin
                        if (tx_done_q) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign uart_tx     = tx_line_q;
    assign fx_wr       = fx_wr_q;
    assign fx_waddr    = fx_waddr_q;
    assign fx_data     = fx_data_q;
    assign fx_rd       = fx_rd_q;
    assign fx_raddr    = fx_raddr_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: doc/commu_uart_bridge.md
Name: commu_uart_bridge

Overview:
- Parametrised UART-slave to fx-bus-master bridge; next generation of the UART command front end.
- Integrates UART RX/TX PHY (internal baud generator, no external µs pulse), a framed command decoder with burst length, an inter-byte timeout and ACK/NAK responses.
- Sits between the board UART pins and the fx bus feeding the register/memory blocks.

Parameters:
- BAUD_DIV, 868: clk_sys cycles per UART bit; minimum 8.
- AW, 22: fx address width; address bytes per frame AB = ceil(AW/8).
- RD_LAT, 1: cycles from fx_rd pulse to valid fx_q; range 1..4.
- TIMEOUT_BITS, 40: idle bit-times allowed between bytes inside a frame before abort.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- uart_rx  in  1  serial in, idle high, asynchronous to clk_sys
- uart_tx  out  1  serial out, idle high
- fx_wr  out  1  one-cycle write strobe
- fx_waddr  out  AW  write address, valid with fx_wr
- fx_data  out  8  write data, valid with fx_wr
- fx_rd  out  1  one-cycle read strobe
- fx_raddr  out  AW  read address, valid with fx_rd
- fx_q  in  8  read data, sampled RD_LAT cycles after fx_rd
- busy  out  1  high while a frame is in progress (not IDLE)

Behaviour:
- Reset values: uart_tx=1, fx_wr=0, fx_rd=0, fx_waddr=0, fx_raddr=0, fx_data=0, busy=0, FSM=IDLE, all counters 0.
- RX PHY:
  - 2-flop synchroniser on uart_rx.
  - Falling edge in idle starts a byte; start bit re-checked at BAUD_DIV/2 (high means glitch, return to idle).
  - 8 data bits LSB first, each sampled mid-bit.
  - Stop bit must be 1, else framing error.
  - Byte valid is a one-cycle pulse at the stop-bit sample.
- TX PHY: 1 start, 8 data LSB first, 1 stop; accepts a byte only when idle; tx_done pulses at the end of the stop bit.
- Frame format:
  - CMD byte: 0x57 = write, 0x52 = read.
  - AB address bytes, MSB first; bits above AW are ignored.
  - LEN byte: N = LEN, with 0 meaning 256.
  - Write frames then carry N data bytes.
- FSM states: IDLE, ADDR, LEN, WDATA, RD_ISSUE, RD_WAIT, RD_TX, RESP.
  - IDLE: a CMD byte moves to ADDR. Any other value moves to RESP with NAK (0x15).
  - ADDR: shift in AB bytes, then go to LEN.
  - LEN: write goes to WDATA; read goes to RD_ISSUE.
  - WDATA:
    - Each received byte gives fx_wr=1 for exactly one cycle, on the cycle after the byte-valid pulse, with fx_waddr=current address and fx_data=byte.
    - Address then increments, wrapping modulo 2^AW.
    - After N bytes, go to RESP with ACK (0x06).
  - RD_ISSUE: fx_rd=1 for one cycle with fx_raddr=current address.
  - RD_WAIT: wait RD_LAT cycles, capture fx_q.
  - RD_TX: send the captured byte; on tx_done, increment the address. If more bytes remain go to RD_ISSUE, else go to IDLE. Read frames send no ACK.
  - RESP: send the response byte; on tx_done go to IDLE.
- Bytes received during RD_ISSUE/RD_WAIT/RD_TX/RESP are discarded.
- Inter-byte timeout:
  - The counter runs in ADDR, LEN and WDATA and clears on each byte-valid.
  - Reaching TIMEOUT_BITS*BAUD_DIV cycles aborts to RESP with NAK.
  - Writes already issued are not rolled back.
- Framing error in ADDR/LEN/WDATA: drop the byte, go to RESP with NAK. In IDLE: drop silently.
- fx_wr and fx_rd are never high in the same cycle.
- Asserting rst mid-frame or mid-transmission returns everything to reset values immediately. A partially sent TX byte is truncated (line forced high).

Optional Feature:
- Macro COMMU_UART_PARITY_EN.
- Defined:
  - RX and TX use an even parity bit between data and stop bits (11-bit character).
  - RX parity mismatch is handled exactly like a framing error (NAK inside a frame, silent drop in IDLE).
- Undefined: 10-bit characters, no parity logic synthesised.

Test Plan:
- Write burst: BAUD_DIV=16, AW=22. Send 57 00 01 00 03 AA BB CC -> three fx_wr pulses: addr 0x000100/AA, 0x000101/BB, 0x000102/CC; then uart_tx returns 0x06; busy low afterwards.
- Read burst: RD_LAT=2, model returns fx_q = low address byte. Send 52 3F FF FE 02 -> fx_rd at 0x3FFFFE then 0x3FFFFF (top address bits ignored); uart_tx returns FE FF; no ACK.
- Address wrap: write 57 3F FF FF 02 11 22 -> writes at 0x3FFFFF then 0x000000; ACK.
- Bad command and timeout:
  - Send 41 -> NAK 0x15, no fx strobes.
  - Send 57 00 00 10 01, then idle for more than 40 bit-times -> NAK, no fx_wr.
- Framing error and reset:
  - Send 57 with stop bit forced 0 while in ADDR -> NAK.
  - Assert rst halfway through a read response -> uart_tx=1, busy=0 within the same cycle; a subsequent write frame completes normally.
- With COMMU_UART_PARITY_EN defined:
  - Send a data byte with wrong parity in WDATA -> NAK, no fx_wr for that byte.
  - Correct-parity frames behave as in the write-burst and read-burst cases, and uart_tx responses carry even parity.
